nrisc_control: RTL

//  Multi-cycle sequencer for the 8-bit nRisc core: owns the PC, fetches instruction bytes from

---
 rtl/nrisc_control.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/nrisc_control.sv
// nrisc_control: multi-cycle sequencer for the 8-bit nRisc core.
// Owns the PC and IR, fetches instruction bytes over a req/ack port, and steps each
// instruction through FETCH/DECODE/(IMM|EXEC|MEM)/WB. Any ack wait longer than
// ACK_TIMEOUT cycles parks the core in FAULT until reset.
module nrisc_control #(
  parameter logic [7:0]  PC_RESET    = 8'h00,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_rdata,
  input  logic       imem_ack,
  output logic [7:0] instr,
  output logic [7:0] imm,
  output logic [2:0] alu_op,
  input  logic       alu_zero,
  output logic       rf_we,
  output logic [1:0] rf_wsel,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  output logic [7:0] pc,
  output logic       halted,
  output logic       fault
);

  localparam int unsigned CntW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(ACK_TIMEOUT);

  localparam logic [2:0] OpLw   = 3'd4;
  localparam logic [2:0] OpSw   = 3'd5;
  localparam logic [2:0] OpLi   = 3'd6;
  localparam logic [2:0] OpBeqz = 3'd7;

  localparam logic [2:0] AluAdd   = 3'd0;
  localparam logic [2:0] AluPassA = 3'd4;

  localparam logic [1:0] WselAlu = 2'd0;
  localparam logic [1:0] WselMem = 2'd1;
  localparam logic [1:0] WselImm = 2'd2;

  typedef enum logic [2:0] {
    StFetch, StDecode, StImm, StExec, StMem, StWb, StHalt, StFault
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      pc_q, pc_d;
  logic [7:0]      instr_q, instr_d;
  logic [7:0]      imm_q, imm_d;
  logic [CntW-1:0] wait_q, wait_d;

  logic [2:0] op;
  logic [1:0] rb;
  logic       is_halt;
  logic [2:0] alu_sel;
  logic [7:0] pc_inc;
  logic       timed_out;

  assign op      = instr_q[7:5];
  assign rb      = instr_q[1:0];
  // 8'hFF would otherwise decode as BEQZ; HALT wins.
  assign is_halt = (instr_q == 8'hFF);
  assign alu_sel = (op == OpBeqz) ? AluPassA : (op[2] == 1'b0) ? op : AluAdd;
  assign pc_inc  = pc_q + 8'd1;
  // ACK_TIMEOUT of zero disables the watchdog entirely.
  assign timed_out = (ACK_TIMEOUT != 0) && (wait_q == TimeoutCnt);

  // State, PC, IR, immediate and wait-counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      pc_q    <= PC_RESET;
      instr_q <= 8'h00;
      imm_q   <= 8'h00;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      imm_q   <= imm_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic and per-state control outputs.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    imm_d     = imm_q;
    wait_d    = wait_q;
    imem_req  = 1'b0;
    imem_addr = pc_q;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    rf_wsel   = WselAlu;
    alu_op    = AluAdd;

    unique case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StDecode;
        end else if (timed_out) begin
          state_d = StFault;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDecode: begin
        if (is_halt) begin
          state_d = StHalt;
        end else begin
          case (op)
            OpLi:       state_d = StImm;
            OpLw, OpSw: state_d = StMem;
            default:    state_d = StExec;
          endcase
        end
      end
      StImm: begin
        imem_req  = 1'b1;
        imem_addr = pc_inc;
        if (imem_ack) begin
          imm_d   = imem_rdata;
          state_d = StWb;
        end else if (timed_out) begin
          state_d = StFault;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StExec: begin
        alu_op = alu_sel;
        if (op == OpBeqz) begin
          // Offset is rb sign-extended (-2..+1), relative to pc+1.
          pc_d    = alu_zero ? (pc_inc + {{6{rb[1]}}, rb}) : pc_inc;
          state_d = StFetch;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = (op == OpSw);
        if (dmem_ack) begin
          if (op == OpSw) begin
            pc_d    = pc_inc;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (timed_out) begin
          state_d = StFault;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StWb: begin
        rf_we   = 1'b1;
        alu_op  = alu_sel;
        rf_wsel = (op == OpLw) ? WselMem : (op == OpLi) ? WselImm : WselAlu;
        pc_d    = (op == OpLi) ? (pc_q + 8'd2) : pc_inc;
        state_d = StFetch;
      end
      StHalt, StFault: begin
      end
      default: begin
        state_d = StFault;
      end
    endcase

    if (state_d != state_q) begin
      wait_d = '0;
    end

    // Reset drops any in-flight request in the same cycle, not at the next edge.
    if (!reset) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
    end
  end

  assign instr  = instr_q;
  assign imm    = imm_q;
  assign pc     = pc_q;
  assign halted = (state_q == StHalt);
  assign fault  = (state_q == StFault);

endmodule
